// File: rtl/lsb_nth_bit_set_finder.sv
// lsb_nth_bit_set_finder: sequential finder for the K-th set bit of a vector.
// Each request is scanned LSB-first or MSB-first. One set bit is cleared per
// cycle until the K-th set bit is reached or the vector is exhausted.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   req_valid_i / req_ready_o   request handshake (ready only in IDLE)
//   vec_i, k_i, msb_first_i     request payload, sampled on acceptance
//   resp_valid_o / resp_ready_i response handshake
//   onehot_o, index_o, found_o  result in original bit order (0 when not found)
module lsb_nth_bit_set_finder #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned IDX_W = $clog2(WIDTH),
    parameter int unsigned K_W   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] vec_i,
    input  logic [K_W-1:0]   k_i,
    input  logic             msb_first_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] onehot_o,
    output logic [IDX_W-1:0] index_o,
    output logic             found_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [K_W-1:0]   k_q;
    logic             msb_q;
    logic [K_W-1:0]   cnt;
    logic [WIDTH-1:0] onehot_q;
    logic [IDX_W-1:0] index_q;
    logic             found_q;
    logic             resp_valid_q;

    logic [WIDTH-1:0] lsb_c;
    logic [WIDTH-1:0] hit_onehot_c;
    logic [IDX_W-1:0] hit_index_c;
    logic [K_W-1:0]   cnt_next_c;

    // Mirror a vector end-for-end (MSB-first scan works on the reversed copy)
    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            r[i] = v[int'(WIDTH) - 1 - i];
        end
        return r;
    endfunction

    // Binary encode of a one-hot vector
    function automatic logic [IDX_W-1:0] encode(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] e;
        e = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (v[i]) begin
                e = e | IDX_W'(i);
            end
        end
        return e;
    endfunction

    // Lowest set bit of the working copy, mapped back to original bit order
    always_comb begin
        lsb_c        = work & (~work + WIDTH'(1));
        hit_onehot_c = msb_q ? bit_rev(lsb_c) : lsb_c;
        hit_index_c  = encode(hit_onehot_c);
        cnt_next_c   = cnt + K_W'(1);
    end

    // Control FSM with registered response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            work         <= '0;
            k_q          <= '0;
            msb_q        <= 1'b0;
            cnt          <= '0;
            onehot_q     <= '0;
            index_q      <= '0;
            found_q      <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        // A zero rank is loaded as an empty vector so it leaves
                        // through the not-found exit one edge later.
                        work  <= (k_i == '0) ? '0
                                 : (msb_first_i ? bit_rev(vec_i) : vec_i);
                        k_q   <= k_i;
                        msb_q <= msb_first_i;
                        cnt   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (work == '0) begin
                        onehot_q     <= '0;
                        index_q      <= '0;
                        found_q      <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state        <= DONE;
                    end else begin
                        cnt  <= cnt_next_c;
                        work <= work & ~lsb_c;
                        if (cnt_next_c == k_q) begin
                            onehot_q     <= hit_onehot_c;
                            index_q      <= hit_index_c;
                            found_q      <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Data outputs keep their last values after the handshake
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o  = (state == IDLE);
    assign resp_valid_o = resp_valid_q;
    assign onehot_o     = onehot_q;
    assign index_o      = index_q;
    assign found_o      = found_q;

endmodule

// File: tb/tb_lsb_nth_bit_set_finder.sv
// tb_lsb_nth_bit_set_finder: directed and random checks of lsb_nth_bit_set_finder
// against a positional-search reference model.
module tb_lsb_nth_bit_set_finder;

    localparam int unsigned WIDTH = 12;
    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned K_W   = $clog2(WIDTH + 1);

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] vec;
    logic [K_W-1:0]   k;
    logic             msb_first;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] onehot;
    logic [IDX_W-1:0] index;
    logic             found;

    int errors = 0;
    int checks = 0;

    lsb_nth_bit_set_finder #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .vec_i        (vec),
        .k_i          (k),
        .msb_first_i  (msb_first),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .onehot_o     (onehot),
        .index_o      (index),
        .found_o      (found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Walk bit positions in scan order and count set bits up to rank kk
    task automatic model(input logic [WIDTH-1:0] v, input int kk, input bit msb,
                         output logic [WIDTH-1:0] oh, output int idx,
                         output bit f, output int lat);
        int cnt;
        int pop;
        int pos;
        cnt = 0; pop = 0; f = 0; oh = '0; idx = 0;
        for (int s = 0; s < int'(WIDTH); s++) begin
            pos = msb ? int'(WIDTH) - 1 - s : s;
            if (v[pos]) begin
                pop++;
                cnt++;
                if (cnt == kk && !f) begin
                    f   = 1;
                    idx = pos;
                    oh  = WIDTH'(1) << pos;
                end
            end
        end
        if (f)            lat = kk;
        else if (kk == 0) lat = 1;
        else              lat = pop + 1;
    endtask

    // Present a request in IDLE and return just after its acceptance edge
    task automatic do_req(input logic [WIDTH-1:0] v, input int kk, input bit msb);
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 1);
        req_valid = 1'b1;
        vec       = v;
        k         = K_W'(kk);
        msb_first = msb;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        vec       = WIDTH'($urandom);
        k         = K_W'($urandom);
        msb_first = 1'($urandom);
    endtask

    // Count edges after acceptance until resp_valid is seen (bounded)
    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!resp_valid && lat < 40);
        chk("resp_valid_seen", 32'(resp_valid), 1);
    endtask

    task automatic finish_resp;
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("resp_valid_drop", 32'(resp_valid), 0);
        chk("req_ready_back", 32'(req_ready), 1);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic run_case(input string tag, input logic [WIDTH-1:0] v, input int kk,
                            input bit msb, input int bp);
        logic [WIDTH-1:0] e_oh;
        int e_idx, e_lat, lat;
        bit e_f;
        model(v, kk, msb, e_oh, e_idx, e_f, e_lat);
        do_req(v, kk, msb);
        wait_resp(lat);
        chk({tag, "_lat"},    32'(lat), 32'(e_lat));
        chk({tag, "_found"},  32'(found), 32'(e_f));
        chk({tag, "_onehot"}, 32'(onehot), 32'(e_oh));
        chk({tag, "_index"},  32'(index), 32'(e_idx));
        chk({tag, "_busy"},   32'(req_ready), 0);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            vec       = WIDTH'($urandom);
            k         = K_W'($urandom);
            @(posedge clk);
            #1;
            chk({tag, "_bp_valid"},  32'(resp_valid), 1);
            chk({tag, "_bp_onehot"}, 32'(onehot), 32'(e_oh));
            chk({tag, "_bp_ready"},  32'(req_ready), 0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        finish_resp();
    endtask

    initial begin
        logic [WIDTH-1:0] rv;
        int lat;
        reset      = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        vec        = '0;
        k          = '0;
        msb_first  = 1'b0;
        #3;
        chk("rst_valid",  32'(resp_valid), 0);
        chk("rst_onehot", 32'(onehot), 0);
        chk("rst_index",  32'(index), 0);
        chk("rst_found",  32'(found), 0);
        chk("rst_ready",  32'(req_ready), 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_case("lsb_hit",   12'h0A6, 2, 1'b0, 0);
        run_case("msb_hit",   12'h0A6, 2, 1'b1, 0);
        run_case("miss",      12'h0A6, 5, 1'b0, 0);
        run_case("k0",        12'h5A5, 0, 1'b0, 0);
        run_case("zero_vec",  12'h000, 1, 1'b0, 0);
        run_case("full_lsb",  12'hFFF, 12, 1'b0, 0);
        run_case("full_msb",  12'hFFF, 12, 1'b1, 0);
        run_case("k_over",    12'hFFF, 15, 1'b0, 0);

        // Backpressure with a competing request held on the request side
        do_req(12'h0A6, 1, 1'b0);
        wait_resp(lat);
        chk("bp_lat", 32'(lat), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            vec       = 12'h0F0;
            k         = K_W'(1);
            msb_first = 1'b0;
            @(posedge clk);
            #1;
            chk("bp_hold_valid",  32'(resp_valid), 1);
            chk("bp_hold_onehot", 32'(onehot), 32'h002);
            chk("bp_hold_index",  32'(index), 1);
            chk("bp_hold_ready",  32'(req_ready), 0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 32'(resp_valid), 0);
        chk("bp_release_ready", 32'(req_ready), 1);
        @(negedge clk);
        resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_second_taken", 32'(req_ready), 0);
        wait_resp(lat);
        chk("bp_second_lat",    32'(lat), 1);
        chk("bp_second_onehot", 32'(onehot), 32'h010);
        chk("bp_second_index",  32'(index), 4);
        finish_resp();

        // Asynchronous reset during the fifth scan step
        do_req(12'hFFF, 12, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        chk("pre_rst_valid", 32'(resp_valid), 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid",  32'(resp_valid), 0);
        chk("mid_rst_onehot", 32'(onehot), 0);
        chk("mid_rst_index",  32'(index), 0);
        chk("mid_rst_found",  32'(found), 0);
        chk("mid_rst_ready",  32'(req_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        run_case("post_rst", 12'h010, 1, 1'b0, 0);

        // Random requests with random backpressure
        for (int n = 0; n < 200; n++) begin
            rv = WIDTH'($urandom);
            if (n % 7 == 0) rv = rv & WIDTH'($urandom);
            run_case("rand", rv, int'($urandom_range(0, 15)), 1'($urandom),
                     int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
